// File: rtl/boot_fetch_if.sv
// ---------------------------------------------------------------------------
// boot_fetch_if
// Bundles the bios boot stream, the instruction-memory bus, the pipeline
// control inputs (stall/redirect) and the IF/ID register outputs of the
// boot/fetch front end.
//
// Signals:
//   boot_valid, boot_data          bios word stream (into the unit)
//   boot_ready, booting            BOOT-phase status (from the unit)
//   mem_addr, mem_wdata            memory address / write data (from the unit)
//   mem_we, mem_oe                 memory write / output enables (from the unit)
//   mem_rdata                      combinational memory read data (into the unit)
//   stall, redirect,
//   redirect_target                pipeline control (into the unit)
//   ifid_instr, ifid_pcpp,
//   ifid_valid                     IF/ID pipeline register (from the unit)
//
// Modports:
//   master  - the fetch unit itself
//   slave   - the surrounding system (bios, memory, decode stage)
// ---------------------------------------------------------------------------
interface boot_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  boot_valid;
    logic [DATA_WIDTH-1:0] boot_data;
    logic                  boot_ready;
    logic                  booting;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  stall;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [DATA_WIDTH-1:0] ifid_instr;
    logic [ADDR_WIDTH-1:0] ifid_pcpp;
    logic                  ifid_valid;

    modport master (
        input  boot_valid, boot_data, mem_rdata, stall, redirect, redirect_target,
        output boot_ready, booting, mem_addr, mem_wdata, mem_we, mem_oe,
               ifid_instr, ifid_pcpp, ifid_valid
    );

    modport slave (
        output boot_valid, boot_data, mem_rdata, stall, redirect, redirect_target,
        input  boot_ready, booting, mem_addr, mem_wdata, mem_we, mem_oe,
               ifid_instr, ifid_pcpp, ifid_valid
    );
endinterface

// File: rtl/boot_fetch_unit.sv
// ---------------------------------------------------------------------------
// boot_fetch_unit
// Instruction-fetch front end with two phases:
//   BOOT  - bios words are written to instruction memory at consecutive
//           addresses starting at 0, one per boot_valid cycle.
//   FETCH - the PC drives the memory address; each advancing cycle captures
//           the instruction and PC+PC_STEP into the IF/ID register.
// FETCH is terminal; only reset returns the unit to BOOT.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - boot_fetch_if.master (boot stream, memory bus, stall/redirect,
//            IF/ID outputs)
// ---------------------------------------------------------------------------
module boot_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    BOOT_WORDS = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 1
) (
    input  logic          clock,
    input  logic          reset,
    boot_fetch_if.master  bus
);

    typedef enum logic {
        S_BOOT  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    // With no boot words the unit comes out of reset already fetching.
    localparam state_t                INIT_STATE = (BOOT_WORDS == 0) ? S_FETCH : S_BOOT;
    localparam logic [ADDR_WIDTH-1:0] LAST_BOOT  = ADDR_WIDTH'((BOOT_WORDS > 0) ? (BOOT_WORDS - 1) : 0);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_boot_addr;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ifid_instr;
    logic [ADDR_WIDTH-1:0] r_ifid_pcpp;
    logic                  r_ifid_valid;

    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] w_boot_addr_next;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] w_ifid_instr_next;
    logic [ADDR_WIDTH-1:0] w_ifid_pcpp_next;
    logic                  w_ifid_valid_next;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    // Modulo 2^ADDR_WIDTH: the all-ones PC simply wraps to zero.
    assign w_pc_inc = r_pc + STEP;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= INIT_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Boot address, PC and IF/ID register (stage boundary IF -> ID)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_boot_addr  <= '0;
            r_pc         <= RESET_PC;
            r_ifid_instr <= '0;
            r_ifid_pcpp  <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_boot_addr  <= w_boot_addr_next;
            r_pc         <= w_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pcpp  <= w_ifid_pcpp_next;
            r_ifid_valid <= w_ifid_valid_next;
        end
    end

    // Next-state and bus outputs
    always_comb begin
        w_state_next      = r_state;
        w_boot_addr_next  = r_boot_addr;
        w_pc_next         = r_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pcpp_next  = r_ifid_pcpp;
        w_ifid_valid_next = r_ifid_valid;

        bus.boot_ready = 1'b0;
        bus.booting    = 1'b0;
        bus.mem_addr   = r_pc;
        bus.mem_wdata  = '0;
        bus.mem_we     = 1'b0;
        bus.mem_oe     = 1'b0;

        case (r_state)
            S_BOOT: begin
                bus.boot_ready = 1'b1;
                bus.booting    = 1'b1;
                bus.mem_addr   = r_boot_addr;
                bus.mem_wdata  = bus.boot_data;
                bus.mem_we     = bus.boot_valid;
                // stall/redirect have no effect here; IF/ID stays cleared.
                if (bus.boot_valid) begin
                    w_boot_addr_next = r_boot_addr + 1'b1;
                    if (r_boot_addr == LAST_BOOT) begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                bus.mem_oe = 1'b1;
                // Redirect wins over stall: a taken branch must flush even
                // when decode is asking to hold.
                if (bus.redirect) begin
                    w_pc_next         = bus.redirect_target;
                    w_ifid_instr_next = '0;
                    w_ifid_pcpp_next  = '0;
                    w_ifid_valid_next = 1'b0;
                end else if (!bus.stall) begin
                    w_pc_next         = w_pc_inc;
                    w_ifid_instr_next = bus.mem_rdata;
                    w_ifid_pcpp_next  = w_pc_inc;
                    w_ifid_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = INIT_STATE;
            end
        endcase
    end

    assign bus.ifid_instr = r_ifid_instr;
    assign bus.ifid_pcpp  = r_ifid_pcpp;
    assign bus.ifid_valid = r_ifid_valid;

endmodule
